// File: rtl/halut_encoder_ctrl.sv
// halut_encoder_ctrl
//   Sequences a bank of HALUT encoder units. It forwards threshold writes to
//   the addressed unit and steps the units through every tree level of every
//   local codebook for each input row.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   cfg_valid_i/ready_o     threshold write handshake (accepted only in IDLE)
//   cfg_unit_i/addr_i/data_i  write target unit, address, value
//   row_valid_i/ready_o     row handshake (cfg has priority)
//   pause_i                 upstream stall; freezes the encode sequence
//   enc_we_o/waddr_o/wdata_o  registered per-unit threshold write port
//   encoder_o               broadcast encode step
//   enc_valid_i             per-unit valid, sampled in DRAIN
//   level_o, c_idx_o        current tree level / local codebook
//   busy_o, row_done_o      not idle / one-cycle row completion
//   err_o                   sticky: bad cfg unit or incomplete units at DRAIN
module halut_encoder_ctrl #(
  parameter int K                  = 16,
  parameter int C                  = 32,
  parameter int EncUnits           = 4,
  parameter int DataTypeWidth      = 16,
  parameter int TreeDepth          = $clog2(K),
  parameter int CPerEncUnit        = C / EncUnits,
  parameter int ThreshMemAddrWidth = $clog2(CPerEncUnit * K),
  parameter int UnitIdxWidth       = (EncUnits > 1) ? $clog2(EncUnits) : 1,
  localparam int LevelWidth        = (TreeDepth > 1) ? $clog2(TreeDepth) : 1,
  localparam int CIdxWidth         = (CPerEncUnit > 1) ? $clog2(CPerEncUnit) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          cfg_valid_i,
  output logic                          cfg_ready_o,
  input  logic [UnitIdxWidth-1:0]       cfg_unit_i,
  input  logic [ThreshMemAddrWidth-1:0] cfg_addr_i,
  input  logic [DataTypeWidth-1:0]      cfg_data_i,
  input  logic                          row_valid_i,
  output logic                          row_ready_o,
  input  logic                          pause_i,
  output logic [EncUnits-1:0]           enc_we_o,
  output logic [ThreshMemAddrWidth-1:0] enc_waddr_o,
  output logic [DataTypeWidth-1:0]      enc_wdata_o,
  output logic                          encoder_o,
  input  logic [EncUnits-1:0]           enc_valid_i,
  output logic [LevelWidth-1:0]         level_o,
  output logic [CIdxWidth-1:0]          c_idx_o,
  output logic                          busy_o,
  output logic                          row_done_o,
  output logic                          err_o
);

  localparam logic [LevelWidth-1:0] LastLevel = LevelWidth'(TreeDepth - 1);
  localparam logic [CIdxWidth-1:0]  LastCIdx  = CIdxWidth'(CPerEncUnit - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENC   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [LevelWidth-1:0]   r_level;
  logic [CIdxWidth-1:0]    r_c_idx;
  logic [EncUnits-1:0]     r_enc_we;
  logic [EncUnits-1:0]     w_enc_we_next;
  logic [ThreshMemAddrWidth-1:0] r_enc_waddr;
  logic [DataTypeWidth-1:0]      r_enc_wdata;
  logic                    r_err;
  logic                    w_cfg_hs;
  logic                    w_row_hs;
  logic                    w_unit_bad;
  logic                    w_last_step;

  assign cfg_ready_o = (r_state == IDLE);
  assign row_ready_o = (r_state == IDLE) && !cfg_valid_i;
  assign busy_o      = (r_state != IDLE);
  assign w_cfg_hs    = cfg_valid_i && cfg_ready_o;
  assign w_row_hs    = row_valid_i && row_ready_o;
  assign w_unit_bad  = w_cfg_hs && (32'(cfg_unit_i) >= EncUnits);
  assign w_last_step = (r_level == LastLevel) && (r_c_idx == LastCIdx);

  assign level_o     = r_level;
  assign c_idx_o     = r_c_idx;
  assign enc_we_o    = r_enc_we;
  assign enc_waddr_o = r_enc_waddr;
  assign enc_wdata_o = r_enc_wdata;
  assign err_o       = r_err;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    encoder_o    = 1'b0;
    row_done_o   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_row_hs) w_state_next = ENC;
      end
      ENC: begin
        encoder_o = !pause_i;
        if (!pause_i && w_last_step) w_state_next = DRAIN;
      end
      DRAIN: begin
        row_done_o   = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Counters are held at zero outside ENC, so leaving the last step into
  // DRAIN and entering ENC from IDLE both see level/c_idx at 0.
  always_ff @(posedge clk_i) begin
    if (rst_i || (r_state != ENC)) begin
      r_level <= '0;
      r_c_idx <= '0;
    end else if (encoder_o) begin
      if (r_level == LastLevel) begin
        r_level <= '0;
        r_c_idx <= (r_c_idx == LastCIdx) ? '0 : r_c_idx + 1'b1;
      end else begin
        r_level <= r_level + 1'b1;
      end
    end
  end

  // Out-of-range unit indices match no bit, so the write is silently dropped.
  always_comb begin
    w_enc_we_next = '0;
    for (int unsigned u = 0; u < EncUnits; u++) begin
      if (w_cfg_hs && (32'(cfg_unit_i) == u)) w_enc_we_next[u] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_enc_we    <= '0;
      r_enc_waddr <= '0;
      r_enc_wdata <= '0;
    end else begin
      r_enc_we <= w_enc_we_next;
      if (w_cfg_hs) begin
        r_enc_waddr <= cfg_addr_i;
        r_enc_wdata <= cfg_data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if (w_unit_bad || ((r_state == DRAIN) && (enc_valid_i != '1))) begin
      r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_halut_encoder_ctrl.sv
// tb_halut_encoder_ctrl
//   Directed bench for halut_encoder_ctrl at default parameters (TreeDepth=4,
//   CPerEncUnit=8), plus a 3-unit instance for the out-of-range cfg unit case.
//   Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_halut_encoder_ctrl;

  localparam int TD         = 4;
  localparam int CPU        = 8;
  localparam int ENC_CYCLES = TD * CPU;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_unit;
  logic [6:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        row_valid;
  logic        row_ready;
  logic        pause;
  logic [3:0]  enc_we;
  logic [6:0]  enc_waddr;
  logic [15:0] enc_wdata;
  logic        encoder;
  logic [3:0]  enc_valid;
  logic [1:0]  level;
  logic [2:0]  c_idx;
  logic        busy;
  logic        row_done;
  logic        err;

  // 3-unit instance (C=24 keeps 8 codebooks per unit); cfg path only
  logic        cfg_valid3;
  logic        cfg_ready3;
  logic [1:0]  cfg_unit3;
  logic        row_ready3;
  logic [2:0]  enc_we3;
  logic [6:0]  enc_waddr3;
  logic [15:0] enc_wdata3;
  logic        encoder3;
  logic [1:0]  level3;
  logic [2:0]  c_idx3;
  logic        busy3;
  logic        row_done3;
  logic        err3;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  halut_encoder_ctrl u_dut (
    .clk_i(clk), .rst_i(rst),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .cfg_unit_i(cfg_unit), .cfg_addr_i(cfg_addr), .cfg_data_i(cfg_data),
    .row_valid_i(row_valid), .row_ready_o(row_ready), .pause_i(pause),
    .enc_we_o(enc_we), .enc_waddr_o(enc_waddr), .enc_wdata_o(enc_wdata),
    .encoder_o(encoder), .enc_valid_i(enc_valid),
    .level_o(level), .c_idx_o(c_idx), .busy_o(busy),
    .row_done_o(row_done), .err_o(err)
  );

  halut_encoder_ctrl #(.K(16), .C(24), .EncUnits(3), .DataTypeWidth(16)) u_dut3 (
    .clk_i(clk), .rst_i(rst),
    .cfg_valid_i(cfg_valid3), .cfg_ready_o(cfg_ready3),
    .cfg_unit_i(cfg_unit3), .cfg_addr_i(cfg_addr), .cfg_data_i(cfg_data),
    .row_valid_i(1'b0), .row_ready_o(row_ready3), .pause_i(1'b0),
    .enc_we_o(enc_we3), .enc_waddr_o(enc_waddr3), .enc_wdata_o(enc_wdata3),
    .encoder_o(encoder3), .enc_valid_i(3'b111),
    .level_o(level3), .c_idx_o(c_idx3), .busy_o(busy3),
    .row_done_o(row_done3), .err_o(err3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else             passed++;
  endtask

  // Entered just after a falling edge with the controller idle. Handshakes a
  // row, optionally pauses pause_len cycles when encode_count reaches
  // pause_at, checks every encode step and the DRAIN cycle.
  task automatic run_row(input int pause_at, input int pause_len, input logic [3:0] valid);
    int  enc_count  = 0;
    int  pause_left = pause_len;
    int  enc_high   = 0;
    bit  seen_done  = 0;
    row_valid = 1'b1;
    enc_valid = valid;
    #1 check("row_ready_idle", row_ready, 1);
    @(posedge clk);
    // t counts cycles after the handshake cycle; DRAIN is expected at
    // t = 32 + pause_len + 1 (cycle 34 when the handshake cycle is cycle 1).
    for (int t = 1; t <= 100; t++) begin
      @(negedge clk);
      row_valid = 1'b0;
      if (enc_count == pause_at && pause_left > 0) begin
        pause = 1'b1;
        pause_left--;
      end else begin
        pause = 1'b0;
      end
      #1;
      if (enc_count < ENC_CYCLES) begin
        check("enc_step", encoder, {31'b0, !pause});
        check("level", level, enc_count % TD);
        check("c_idx", c_idx, enc_count / TD);
        check("no_done_in_enc", row_done, 0);
        if (encoder) enc_high++;
        if (!pause) enc_count++;
      end else begin
        check("done_cycle", t, ENC_CYCLES + pause_len + 1);
        check("row_done", row_done, 1);
        check("drain_enc", encoder, 0);
        check("drain_level", level, 0);
        check("drain_cidx", c_idx, 0);
        check("drain_busy", busy, 1);
        seen_done = 1;
        break;
      end
    end
    pause = 1'b0;
    check("row_finished", seen_done, 1);
    check("enc_high_count", enc_high, ENC_CYCLES);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done_seen;
    rst = 1'b1; cfg_valid = 1'b0; cfg_unit = '0; cfg_addr = '0; cfg_data = '0;
    row_valid = 1'b0; pause = 1'b0; enc_valid = 4'hF;
    cfg_valid3 = 1'b0; cfg_unit3 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_busy", busy, 0);
    check("rst_we", enc_we, 0);
    check("rst_waddr", enc_waddr, 0);
    check("rst_wdata", enc_wdata, 0);
    check("rst_encoder", encoder, 0);
    check("rst_row_done", row_done, 0);
    check("rst_err", err, 0);
    check("rst_level", level, 0);
    check("rst_cidx", c_idx, 0);
    rst = 1'b0;

    // single config write: unit 2, addr 0x05, data 0x3C00
    @(negedge clk);
    cfg_valid = 1'b1; cfg_unit = 2'd2; cfg_addr = 7'h05; cfg_data = 16'h3C00;
    #1 check("cfg_ready_idle", cfg_ready, 1);
    check("row_ready_cfg_pending", row_ready, 0);
    @(negedge clk);
    cfg_valid = 1'b0;
    #1 check("cfg_we", enc_we, 4'b0100);
    check("cfg_waddr", enc_waddr, 7'h05);
    check("cfg_wdata", enc_wdata, 16'h3C00);
    @(negedge clk); #1 check("cfg_we_clear", enc_we, 0);

    // back-to-back writes to units 0 and 3
    cfg_valid = 1'b1; cfg_unit = 2'd0; cfg_addr = 7'h11; cfg_data = 16'hAAAA;
    @(negedge clk);
    cfg_unit = 2'd3; cfg_addr = 7'h7F; cfg_data = 16'h5555;
    #1 check("b2b_we0", enc_we, 4'b0001);
    check("b2b_waddr0", enc_waddr, 7'h11);
    check("b2b_wdata0", enc_wdata, 16'hAAAA);
    @(negedge clk);
    cfg_valid = 1'b0;
    #1 check("b2b_we3", enc_we, 4'b1000);
    check("b2b_waddr3", enc_waddr, 7'h7F);
    check("b2b_wdata3", enc_wdata, 16'h5555);
    @(negedge clk); #1 check("b2b_we_clear", enc_we, 0);

    // 3-unit instance: unit 2 is valid, unit 3 is dropped and flags err
    cfg_valid3 = 1'b1; cfg_unit3 = 2'd2;
    @(negedge clk);
    cfg_unit3 = 2'd3;
    #1 check("u3_we_ok", enc_we3, 3'b100);
    check("u3_err_ok", err3, 0);
    @(negedge clk);
    cfg_valid3 = 1'b0;
    #1 check("u3_we_drop", enc_we3, 3'b000);
    check("u3_err_set", err3, 1);
    check("err_main_clean", err, 0);

    // plain row, no pause
    @(negedge clk);
    run_row(-1, 0, 4'hF);
    @(negedge clk); #1;
    check("idle_after_row", busy, 0);
    check("err_after_good", err, 0);
    check("done_pulse_1cyc", row_done, 0);

    // row with a 5-cycle pause at level 2, c_idx 3
    @(negedge clk);
    run_row(3 * TD + 2, 5, 4'hF);
    @(negedge clk); #1 check("err_after_pause", err, 0);

    // cfg and row requested together: cfg first, row next cycle
    @(negedge clk);
    cfg_valid = 1'b1; cfg_unit = 2'd1; cfg_addr = 7'h07; cfg_data = 16'h1234;
    row_valid = 1'b1;
    #1 check("prio_row_ready", row_ready, 0);
    check("prio_cfg_ready", cfg_ready, 1);
    @(negedge clk);
    cfg_valid = 1'b0;
    #1 check("prio_we", enc_we, 4'b0010);
    check("prio_still_idle", busy, 0);
    run_row(-1, 0, 4'hF);

    // incomplete units at DRAIN set the sticky error
    @(negedge clk);
    run_row(-1, 0, 4'b1011);
    @(negedge clk); #1 check("err_set", err, 1);
    run_row(-1, 0, 4'hF);
    @(negedge clk); #1 check("err_sticky", err, 1);

    // reset during encode cycle 17 aborts the row
    row_valid = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 17; n++) begin
      @(negedge clk);
      row_valid = 1'b0;
    end
    rst = 1'b1;
    #1 check("pre_rst_level", level, 0);
    check("pre_rst_cidx", c_idx, 4);
    check("pre_rst_enc", encoder, 1);
    @(negedge clk);
    rst = 1'b0;
    #1 check("abort_busy", busy, 0);
    check("abort_encoder", encoder, 0);
    check("abort_level", level, 0);
    check("abort_cidx", c_idx, 0);
    check("abort_row_done", row_done, 0);
    check("abort_err_clr", err, 0);
    done_seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk); #1;
      if (row_done || busy) done_seen = 1;
    end
    check("abort_no_done", done_seen, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/halut_encoder_ctrl.md
HALUT_ENCODER_CTRL -- requirements
Module: halut_encoder_ctrl

Interface
REQ-001 Parameters SHALL be:
- K, default 16, prototypes per codebook.
- C, default 32, total codebooks.
- EncUnits, default 4, number of encoder units sequenced.
- DataTypeWidth, default 16, threshold width.
- TreeDepth, default $clog2(K).
- CPerEncUnit, default C/EncUnits.
- ThreshMemAddrWidth, default $clog2(CPerEncUnit*K).
- UnitIdxWidth, default max(1,$clog2(EncUnits)).
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- cfg_valid_i  in  1  threshold write request.
- cfg_ready_o  out  1  write accepted when high with cfg_valid_i.
- cfg_unit_i  in  UnitIdxWidth  target encoder unit.
- cfg_addr_i  in  ThreshMemAddrWidth  threshold address.
- cfg_data_i  in  DataTypeWidth  threshold value.
- row_valid_i  in  1  input row available for encoding.
- row_ready_o  out  1  row accepted.
- pause_i  in  1  upstream cannot supply inputs this cycle.
- enc_we_o  out  EncUnits  per-unit threshold write enable.
- enc_waddr_o  out  ThreshMemAddrWidth  shared write address.
- enc_wdata_o  out  DataTypeWidth  shared write data.
- encoder_o  out  1  encode step, broadcast to all units.
- enc_valid_i  in  EncUnits  unit valid outputs.
- level_o  out  $clog2(TreeDepth)  current tree level.
- c_idx_o  out  $clog2(CPerEncUnit)  current local codebook.
- busy_o  out  1  state != IDLE.
- row_done_o  out  1  one-cycle row completion pulse.
- err_o  out  1  sticky completion error.
REQ-003 The block SHALL have one clock, clk_i, and a synchronous active-high reset, rst_i; all flops SHALL update only on the rising edge of clk_i.

Function
REQ-004 The state machine SHALL have the states IDLE, ENC and DRAIN.
REQ-005 cfg_ready_o SHALL be high only in IDLE.
REQ-006 row_ready_o SHALL equal IDLE && !cfg_valid_i, giving configuration priority over encoding.
REQ-007 A cfg handshake SHALL drive enc_we_o[cfg_unit_i]=1, enc_waddr_o=cfg_addr_i and enc_wdata_o=cfg_data_i in the next cycle only (registered, 1-cycle latency). Back-to-back writes SHALL sustain one write per cycle.
REQ-008 If cfg_unit_i >= EncUnits, the write SHALL be accepted and dropped (enc_we_o=0), and err_o SHALL be set.
REQ-009 A row handshake in IDLE SHALL move the state to ENC with level_o=0 and c_idx_o=0.
REQ-010 In ENC:
- encoder_o SHALL be !pause_i, combinationally.
- On each cycle with encoder_o=1, level_o SHALL increment.
- At level TreeDepth-1, level_o SHALL wrap to 0 and c_idx_o SHALL increment.
- When encoder_o=1 at level TreeDepth-1 and c_idx CPerEncUnit-1, the state SHALL move to DRAIN.
REQ-011 A row SHALL therefore see exactly TreeDepth*CPerEncUnit cycles with encoder_o=1, which keeps the unit-internal level and codebook counters aligned across rows.
REQ-012 pause_i SHALL freeze level_o and c_idx_o and hold encoder_o=0; there is no cycle limit on the pause.
REQ-013 DRAIN SHALL last exactly one cycle, with encoder_o=0 and row_done_o=1. If enc_valid_i is not all-ones in that cycle, err_o SHALL be set. The next state SHALL be IDLE.
REQ-014 level_o and c_idx_o SHALL be 0 in IDLE and in DRAIN.
REQ-015 cfg_valid_i and row_valid_i SHALL be ignored outside IDLE; requesters hold them until ready.
REQ-016 err_o SHALL be cleared only by rst_i.

Reset
REQ-017 While rst_i=1 at a clock edge, the block SHALL set:
- state=IDLE and all counters to 0;
- enc_we_o=0, enc_waddr_o=0, enc_wdata_o=0;
- encoder_o=0, row_done_o=0, err_o=0, busy_o=0.
REQ-018 A reset asserted mid-ENC SHALL abort the row without a row_done_o pulse. Encoder units reset alongside.

Verification (K=16, C=32, EncUnits=4: TreeDepth=4, CPerEncUnit=8)
REQ-019 Config write: cfg unit=2, addr=0x05, data=0x3C00 -> next cycle enc_we_o=4'b0100, enc_waddr_o=0x05, enc_wdata_o=0x3C00; the cycle after, enc_we_o=0.
REQ-020 Single row, no pause, units return valid -> encoder_o high for exactly 32 consecutive cycles; level_o sequence 0,1,2,3 repeats with c_idx_o 0..7; row_done_o pulses on cycle 34 after the handshake; err_o=0.
REQ-021 Same row with pause_i high for 5 cycles at level=2, c_idx=3 -> counters hold; 32 encode cycles total; row_done_o is delayed by 5 cycles.
REQ-022 cfg_valid_i and row_valid_i asserted together in IDLE -> the cfg is accepted first, row_ready_o=0 that cycle, and the row is accepted the following cycle.
REQ-023 enc_valid_i=4'b1011 during DRAIN -> err_o=1 and stays set through subsequent rows until rst_i.
REQ-024 rst_i asserted at encode cycle 17 -> the next cycle shows IDLE, encoder_o=0, level_o=0, c_idx_o=0, and no row_done_o pulse.
